// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if: valid/ready handshake carrying payload words into the UART transmitter
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter fed by a small handshake FIFO, frames sent back to back
module uart_tx_param #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    uart_tx_param_if.slave                tx,
    output logic                          txd,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int NW = $clog2(DATA_BITS + 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_bad_param
        $error("uart_tx_param: illegal parameter combination");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state;
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        baud;
    logic [NW-1:0]        bit_cnt;
    logic                 par;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;

    assign tx.tx_ready = fifo_count != CW'(FIFO_DEPTH);
    assign push        = tx.tx_valid && tx.tx_ready;
    assign head        = mem[rd_ptr];
    assign bit_end     = baud == BW'(CLKS_PER_BIT - 1);
    assign last_stop   = state == STOP && bit_end && bit_cnt == NW'(STOP_BITS - 1);
    assign pop         = fifo_count != '0 && (state == IDLE || last_stop);

    // FIFO storage captures tx_data only on an accepted push
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx.tx_data;
    end

    // FIFO pointers wrap naturally at the power-of-two depth; push and pop together keep the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    // Frame sequencer: txd and busy are registered and change together with the state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            txd     <= 1'b1;
            busy    <= 1'b0;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
        end else begin
            baud <= (bit_end || state == IDLE) ? '0 : baud + BW'(1);
            if (pop) begin
                shreg <= head;
                par   <= (^head) ^ (PARITY == 1);
                state <= START;
                txd   <= 1'b0;
                busy  <= 1'b1;
            end else begin
                case (state)
                    IDLE: ;
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                            txd     <= shreg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            if (bit_cnt == NW'(DATA_BITS - 1)) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? PAR : STOP;
                                txd     <= (PARITY != 0) ? par : 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + NW'(1);
                                shreg   <= shreg >> 1;
                                txd     <= shreg[1];
                            end
                        end
                    end
                    PAR: begin
                        if (bit_end) begin
                            state   <= STOP;
                            bit_cnt <= '0;
                            txd     <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (last_stop) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            txd   <= 1'b1;
                        end else if (bit_end) begin
                            bit_cnt <= bit_cnt + NW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed checks of four UART transmitter configurations
module tb_uart_tx_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [3:0] v = '0;
    logic [3:0] rdy;
    logic [3:0] txd_w;
    logic [3:0] busy_w;
    logic [3:0][2:0] cnt;
    logic [8:0] d [4];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    uart_tx_param_if #(.DATA_BITS(8)) i0 ();
    uart_tx_param_if #(.DATA_BITS(8)) i1 ();
    uart_tx_param_if #(.DATA_BITS(8)) i2 ();
    uart_tx_param_if #(.DATA_BITS(5)) i3 ();

    assign i0.tx_valid = v[0];
    assign i1.tx_valid = v[1];
    assign i2.tx_valid = v[2];
    assign i3.tx_valid = v[3];
    assign i0.tx_data  = d[0][7:0];
    assign i1.tx_data  = d[1][7:0];
    assign i2.tx_data  = d[2][7:0];
    assign i3.tx_data  = d[3][4:0];
    assign rdy         = {i3.tx_ready, i2.tx_ready, i1.tx_ready, i0.tx_ready};

    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .tx(i0), .txd(txd_w[0]), .busy(busy_w[0]), .fifo_count(cnt[0]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .tx(i1), .txd(txd_w[1]), .busy(busy_w[1]), .fifo_count(cnt[1]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .tx(i2), .txd(txd_w[2]), .busy(busy_w[2]), .fifo_count(cnt[2]));
    uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .tx(i3), .txd(txd_w[3]), .busy(busy_w[3]), .fifo_count(cnt[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [8:0] val);
        int n = 0;
        d[k] = val;
        v[k] = 1'b1;
        while (!rdy[k] && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("ready%0d", k), 32'(rdy[k]), 1);
        tick();
        v[k] = 1'b0;
    endtask

    task automatic wait_start(input int k);
        int n = 0;
        while (txd_w[k] !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        chk($sformatf("start%0d", k), 32'(txd_w[k]), 0);
    endtask

    task automatic frame(input int k, input logic [15:0] e, input int nb, input string tag);
        logic [3:0] g;
        for (int i = 0; i < nb; i++) begin
            for (int j = 0; j < 4; j++) begin
                g[j] = txd_w[k];
                tick();
            end
            chk($sformatf("%s bit%0d", tag, i), 32'(g), 32'({4{e[i]}}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic seen;
        for (int k = 0; k < 4; k++) d[k] = '0;
        tick(3);
        rst = 1'b1;
        tick();
        chk("rst txd", 32'(txd_w[0]), 1);
        chk("rst busy", 32'(busy_w[0]), 0);
        chk("rst ready", 32'(rdy[0]), 1);
        chk("rst count", 32'(cnt[0]), 0);

        push(0, 9'h0A5);
        chk("lat txd high", 32'(txd_w[0]), 1);
        tick();
        chk("lat txd low", 32'(txd_w[0]), 0);
        chk("busy rise", 32'(busy_w[0]), 1);
        frame(0, 16'b1101001010, 10, "a5");
        chk("busy a5 end", 32'(busy_w[0]), 0);

        push(1, 9'h007);
        tick();
        frame(1, 16'b11000001110, 11, "even07");
        chk("busy even end", 32'(busy_w[1]), 0);

        push(2, 9'h007);
        tick();
        frame(2, 16'b110000001110, 12, "odd07");
        chk("busy odd end", 32'(busy_w[2]), 0);

        push(3, 9'h01F);
        tick();
        frame(3, 16'b1111110, 7, "d5_1f");
        chk("busy d5 end", 32'(busy_w[3]), 0);
        chk("txd d5 idle", 32'(txd_w[3]), 1);

        fork
            begin
                int n = 0;
                push(0, 9'h001);
                chk("q cnt1", 32'(cnt[0]), 1);
                push(0, 9'h002);
                chk("q cnt2", 32'(cnt[0]), 1);
                push(0, 9'h003);
                push(0, 9'h004);
                push(0, 9'h005);
                chk("q full cnt", 32'(cnt[0]), 4);
                chk("q full ready", 32'(rdy[0]), 0);
                while (!rdy[0] && n < 100) begin
                    tick();
                    n++;
                end
                chk("q ready cnt", 32'(cnt[0]), 3);
                push(0, 9'h006);
                chk("q refill cnt", 32'(cnt[0]), 4);
            end
            begin
                wait_start(0);
                for (int f = 1; f <= 6; f++)
                    frame(0, {6'd0, 1'b1, 8'(f), 1'b0}, 10, $sformatf("q%0d", f));
                chk("q busy end", 32'(busy_w[0]), 0);
                chk("q cnt end", 32'(cnt[0]), 0);
            end
        join

        fork
            begin
                push(0, 9'h011);
                push(0, 9'h012);
                push(0, 9'h013);
                push(0, 9'h014);
                chk("pp cnt3", 32'(cnt[0]), 3);
                tick(37);
                chk("pp pre cnt", 32'(cnt[0]), 3);
                push(0, 9'h015);
                chk("pp same cycle cnt", 32'(cnt[0]), 3);
                push(0, 9'h016);
                chk("pp full cnt", 32'(cnt[0]), 4);
            end
            begin
                wait_start(0);
                for (int f = 1; f <= 6; f++)
                    frame(0, {6'd0, 1'b1, 8'(16 + f), 1'b0}, 10, $sformatf("pp%0d", f));
                chk("pp busy end", 32'(busy_w[0]), 0);
            end
        join

        push(0, 9'h021);
        push(0, 9'h022);
        push(0, 9'h023);
        tick(6);
        chk("ab queued", 32'(cnt[0]), 2);
        chk("ab busy", 32'(busy_w[0]), 1);
        rst = 1'b0;
        #1;
        chk("ab txd", 32'(txd_w[0]), 1);
        chk("ab busy low", 32'(busy_w[0]), 0);
        chk("ab cnt", 32'(cnt[0]), 0);
        chk("ab ready", 32'(rdy[0]), 1);
        tick(2);
        rst = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) seen = 1'b1;
            tick();
        end
        chk("ab quiet", 32'(seen), 0);
        chk("ab cnt after", 32'(cnt[0]), 0);
        push(0, 9'h033);
        tick();
        frame(0, 16'b1001100110, 10, "ab33");
        chk("ab busy end", 32'(busy_w[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
